// File: rtl/fpu_mult_sched.sv
// fpu_mult_sched: two-requester scheduler in front of one shared single-precision
// multiply datapath. Stage 1 registers the granted request's raw operands; stage 2
// registers sign, biased prenormalized exponent and the full mantissa product,
// tagged with the requester ID, toward the normalizer under valid/ready backpressure.
// Build option: define FPU_MULT_SCHED_RR_EN for round-robin arbitration; when it is
// left undefined, requester 0 always wins over requester 1.
module fpu_mult_sched #(
    parameter int unsigned C_EXP         = 8,
    parameter int unsigned C_MANT        = 23,
    parameter int unsigned C_BIAS        = 127,
    parameter int unsigned C_EXP_PRENORM = C_EXP + 2,
    parameter int unsigned C_MANT_PROD   = 2 * C_MANT + 2
) (
    input  logic                          Clk_CI,
    input  logic                          Rst_RBI,
    input  logic                          Flush_SI,
    input  logic [1:0]                    Valid_SI,
    output logic [1:0]                    Ready_SO,
    input  logic [1:0]                    Sign_a_DI,
    input  logic [1:0]                    Sign_b_DI,
    input  logic [2*C_EXP-1:0]            Exp_a_DI,
    input  logic [2*C_EXP-1:0]            Exp_b_DI,
    input  logic [2*(C_MANT+1)-1:0]       Mant_a_DI,
    input  logic [2*(C_MANT+1)-1:0]       Mant_b_DI,
    output logic                          Valid_SO,
    input  logic                          Ready_SI,
    output logic                          Tag_DO,
    output logic                          Sign_prenorm_DO,
    output logic [C_EXP_PRENORM-1:0]      Exp_prenorm_DO,
    output logic [C_MANT_PROD-1:0]        Mant_prenorm_DO,
    output logic                          Busy_SO
);

    localparam int unsigned C_MW = C_MANT + 1;

    // Stage 1: accepted request, raw operands
    logic                     r_s1Valid;
    logic                     r_s1Tag;
    logic                     r_s1SignA;
    logic                     r_s1SignB;
    logic [C_EXP-1:0]         r_s1ExpA;
    logic [C_EXP-1:0]         r_s1ExpB;
    logic [C_MW-1:0]          r_s1MantA;
    logic [C_MW-1:0]          r_s1MantB;

    // Stage 2: computed result, drives the outputs directly
    logic                     r_s2Valid;
    logic                     r_s2Tag;
    logic                     r_s2Sign;
    logic [C_EXP_PRENORM-1:0] r_s2Exp;
    logic [C_MANT_PROD-1:0]   r_s2Mant;

    logic                     w_en1;
    logic                     w_en2;
    logic [1:0]               w_grant;
    logic                     w_accepted;
    logic                     w_sel;
    logic                     w_selSignA;
    logic                     w_selSignB;
    logic [C_EXP-1:0]         w_selExpA;
    logic [C_EXP-1:0]         w_selExpB;
    logic [C_MW-1:0]          w_selMantA;
    logic [C_MW-1:0]          w_selMantB;
    logic [C_EXP_PRENORM-1:0] w_expSum;
    logic [C_MANT_PROD-1:0]   w_mantProd;

    // Stage 2 frees up when empty or when the consumer takes its result;
    // stage 1 may load when empty or when its entry moves into stage 2.
    assign w_en2 = ~r_s2Valid | Ready_SI;
    assign w_en1 = ~r_s1Valid | w_en2;

    // Flush wins over any handshake in the same cycle
    assign Ready_SO   = w_grant & {2{w_en1 & ~Flush_SI}};
    assign w_accepted = |Ready_SO;
    assign w_sel      = Ready_SO[1];

`ifdef FPU_MULT_SCHED_RR_EN
    logic r_prio;

    // Preference passes to the other requester after every accepted request
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_prio <= 1'b0;
        end else if (w_accepted) begin
            r_prio <= ~w_sel;
        end
    end

    // Round-robin grant: a lone requester wins, ties go to the preferred one
    always_comb begin
        w_grant = Valid_SI;
        if (Valid_SI == 2'b11) begin
            w_grant = r_prio ? 2'b10 : 2'b01;
        end
    end
`else
    // Fixed-priority grant: requester 0 always beats requester 1
    always_comb begin
        w_grant[0] = Valid_SI[0];
        w_grant[1] = Valid_SI[1] & ~Valid_SI[0];
    end
`endif

    assign w_selSignA = w_sel ? Sign_a_DI[1] : Sign_a_DI[0];
    assign w_selSignB = w_sel ? Sign_b_DI[1] : Sign_b_DI[0];
    assign w_selExpA  = w_sel ? Exp_a_DI[2*C_EXP-1:C_EXP] : Exp_a_DI[C_EXP-1:0];
    assign w_selExpB  = w_sel ? Exp_b_DI[2*C_EXP-1:C_EXP] : Exp_b_DI[C_EXP-1:0];
    assign w_selMantA = w_sel ? Mant_a_DI[2*C_MW-1:C_MW] : Mant_a_DI[C_MW-1:0];
    assign w_selMantB = w_sel ? Mant_b_DI[2*C_MW-1:C_MW] : Mant_b_DI[C_MW-1:0];

    // Stage 1 captures the granted operands; a flush drops whatever it holds
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_s1Valid <= 1'b0;
            r_s1Tag   <= 1'b0;
            r_s1SignA <= 1'b0;
            r_s1SignB <= 1'b0;
            r_s1ExpA  <= '0;
            r_s1ExpB  <= '0;
            r_s1MantA <= '0;
            r_s1MantB <= '0;
        end else if (Flush_SI) begin
            r_s1Valid <= 1'b0;
        end else if (w_en1) begin
            r_s1Valid <= w_accepted;
            if (w_accepted) begin
                r_s1Tag   <= w_sel;
                r_s1SignA <= w_selSignA;
                r_s1SignB <= w_selSignB;
                r_s1ExpA  <= w_selExpA;
                r_s1ExpB  <= w_selExpB;
                r_s1MantA <= w_selMantA;
                r_s1MantB <= w_selMantB;
            end
        end
    end

    // Exponents are zero-extended so the biased sum cannot wrap; the result is
    // read as signed. The mantissa product keeps every bit.
    assign w_expSum   = C_EXP_PRENORM'(r_s1ExpA) + C_EXP_PRENORM'(r_s1ExpB)
                      - C_EXP_PRENORM'(C_BIAS);
    assign w_mantProd = C_MANT_PROD'(r_s1MantA) * C_MANT_PROD'(r_s1MantB);

    // Stage 2 registers the computed result; payload only changes when a new
    // entry arrives so outputs hold steady while the consumer stalls
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_s2Valid <= 1'b0;
            r_s2Tag   <= 1'b0;
            r_s2Sign  <= 1'b0;
            r_s2Exp   <= '0;
            r_s2Mant  <= '0;
        end else if (Flush_SI) begin
            r_s2Valid <= 1'b0;
        end else if (w_en2) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2Tag  <= r_s1Tag;
                r_s2Sign <= r_s1SignA ^ r_s1SignB;
                r_s2Exp  <= w_expSum;
                r_s2Mant <= w_mantProd;
            end
        end
    end

    assign Valid_SO        = r_s2Valid;
    assign Tag_DO          = r_s2Tag;
    assign Sign_prenorm_DO = r_s2Sign;
    assign Exp_prenorm_DO  = r_s2Exp;
    assign Mant_prenorm_DO = r_s2Mant;
    assign Busy_SO         = r_s1Valid | r_s2Valid;

endmodule
